mdr_handshake: RTL and testbench
================================

# mdr_handshake

Parametrised memory data register with a built-in memory handshake controller. It replaces the plain bus-or-memory-loaded MDR in the datapath. It holds the data word exchanged between the internal bus and memory, runs the request/acknowledge sequence for reads and writes, and performs byte/halfword lane alignment with sign or zero extension. A timeout counter guarantees the CPU control unit never hangs on a missing acknowledge.

## Interface
- WIDTH, 32, data width; legal values 32 or 64
- LANES, WIDTH/8, byte lanes (derived, not overridden)
- AW, $clog2(LANES), byte-offset width (derived)
- TIMEOUT, 15, max wait cycles for mem_ack; legal range 1..255
- clk  in  1  single clock; all state updates on rising edge
- clr  in  1  asynchronous, active-low reset
- mdr_in  in  1  load q from bus_mux_out (honoured only in IDLE)
- bus_mux_out  in  WIDTH  data from the bus mux
- rd_start  in  1  begin memory read (sampled in IDLE)
- wr_start  in  1  begin memory write of q (sampled in IDLE)
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 full WIDTH
- sign_ext  in  1  1 = sign-extend sub-width reads, 0 = zero-extend
- addr_lo  in  AW  byte offset of the access; sampled with start
- mem_rdata  in  WIDTH  read data from memory
- mem_ack  in  1  memory acknowledge
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write request, registered
- mem_wdata  out  WIDTH  write data, lane-replicated
- mem_be  out  LANES  byte enables
- q  out  WIDTH  register contents, to bus and ALU
- busy  out  1  high in RD or WR
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse, coincident with done

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - rd_start → RD.
  - wr_start (without rd_start) → WR.
  - If both are high, the read wins and the write is dropped.
  - size, sign_ext and addr_lo are latched on the start cycle.
  - mdr_in loads q ← bus_mux_out. If mdr_in coincides with a start, the load occurs first; a write then uses the newly loaded value.
- Outside IDLE, mdr_in, rd_start and wr_start are ignored.
- RD:
  - mem_req=1, mem_we=0, mem_be from latched size/offset.
  - On mem_ack, extract the addressed lane from mem_rdata, extend it to WIDTH, write it to q, and go to DONE.
- WR:
  - mem_req=1, mem_we=1.
  - mem_wdata replicates the low sub-word of q across all lanes: byte → LANES copies of q[7:0]; half → copies of q[15:0]; word → copies of q[31:0].
  - mem_be has ones only for the addressed lanes.
  - On mem_ack → DONE; q is unchanged.
- Alignment: the offset is aligned down to the access size (half ignores bit 0; word ignores bits 1:0; full ignores all). When WIDTH=32, size 11 is equal to 10.
- Timeout:
  - The counter clears on entry to RD or WR and increments on each cycle without an ack.
  - If it reaches TIMEOUT, go to DONE with err flagged; q is unchanged.
  - An ack in the same cycle as the final count wins: the transfer completes and err stays 0.
- DONE: done=1 (err=1 if timed out), mem_req=0, then → IDLE unconditionally.
- mem_ack in IDLE or DONE is ignored.

## Timing
- Reset: state IDLE, q=0, mem_req=0, mem_we=0, mem_wdata=0, mem_be=0, busy=0, done=0, err=0, counter=0.
- Reset takes effect immediately, including mid-transfer. mem_req drops asynchronously and the transfer is abandoned.
- Start at edge N → mem_req, busy high from N+1.
- mem_ack sampled high at edge M → q updated at M (reads). In cycle M+1, mem_req=0, busy=0 and done=1.
- Minimum latency is start to done = 2 cycles (ack in the first request cycle).
- Timeout: with no ack, done/err are asserted in cycle N+1+TIMEOUT.
- A new start is accepted in the cycle after DONE, which gives back-to-back throughput of one access per 3 cycles minimum.
- mem_req, mem_we, mem_be and mem_wdata are held stable from request until the cycle after ack.

## Structure
- Package mdr_pkg:
  - size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_FULL)
  - state enum
  - helper function for byte-enable generation
- Sub-module mdr_lane_align: combinational read-lane extraction and extension (WIDTH, size, offset, sign_ext). It is instantiated once in mdr_handshake.

## Test plan
- Reset then mdr_in with bus_mux_out=0xDEADBEEF in IDLE → q=0xDEADBEEF next cycle; mem_req stays 0.
- Byte read, addr_lo=2, sign_ext=1, mem_rdata=0x1280_3456, ack on first request cycle → q=0xFFFF_FF80, done 2 cycles after start, mem_be=0100.
- Half write, q=0x0000_ABCD, addr_lo=3 (aligned to 2) → mem_wdata=0xABCD_ABCD, mem_be=1100, mem_we=1 until ack, q unchanged.
- Read with TIMEOUT=4 and no ack → done=err=1 five cycles after start, mem_req low, q keeps its prior value. Repeat with ack on the 4th wait cycle → err=0.
- rd_start and wr_start together, then mdr_in and rd_start pulsed while busy → read performed, write dropped, busy-time inputs ignored.
- Assert clr mid-RD → all outputs zero immediately; after release, a fresh word read of 0x0123_4567 completes normally.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared types and helpers for the memory data register: access-size and FSM encodings,
// lane alignment of the byte offset and byte-enable generation (sized for up to 8 lanes).
package mdr_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_FULL = 2'b11
    } mdr_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } mdr_state_e;

    localparam int unsigned MAX_LANES = 8;
    localparam int unsigned CNT_W     = 8;

    // Bytes touched by an access; SZ_FULL and oversize requests collapse to the bus width.
    function automatic logic [3:0] size_bytes(input mdr_size_e sz, input logic [3:0] lanes);
        logic [3:0] n;
        case (sz)
            SZ_BYTE: n = 4'd1;
            SZ_HALF: n = 4'd2;
            SZ_WORD: n = 4'd4;
            default: n = 4'd8;
        endcase
        if (n > lanes) begin
            n = lanes;
        end
        return n;
    endfunction

    function automatic logic [2:0] align_off(input mdr_size_e sz, input logic [2:0] off,
                                             input logic [3:0] lanes);
        logic [3:0] n;
        n = size_bytes(sz, lanes);
        return off & ~(n[2:0] - 3'd1) & (lanes[2:0] - 3'd1);
    endfunction

    // An 8-byte access wraps the shifted one to zero, so the decrement yields all ones.
    function automatic logic [MAX_LANES-1:0] be_gen(input mdr_size_e sz, input logic [2:0] off,
                                                    input logic [3:0] lanes);
        logic [3:0]           n;
        logic [MAX_LANES-1:0] m;
        n = size_bytes(sz, lanes);
        m = (8'd1 << n) - 8'd1;
        return m << align_off(sz, off, lanes);
    endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Read-lane extraction: shifts the addressed sub-word of the memory data down to bit 0
// and sign- or zero-extends it to the full width. Purely combinational.
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int LANES = WIDTH / 8,
    localparam int AW    = $clog2(LANES)
) (
    input  logic [WIDTH-1:0] rdata_i,
    input  logic [1:0]       size_i,
    input  logic [AW-1:0]    off_i,
    input  logic             sext_i,
    output logic [WIDTH-1:0] ext_o
);

    logic [2:0]       aoff;
    logic [WIDTH-1:0] sh;

    assign aoff = align_off(mdr_size_e'(size_i), 3'(off_i), 4'(LANES));
    assign sh   = rdata_i >> {aoff, 3'b000};

    always_comb begin
        ext_o = sh;
        case (mdr_size_e'(size_i))
            SZ_BYTE: begin
                for (int i = 8; i < WIDTH; i++) begin
                    ext_o[i] = sext_i & sh[7];
                end
            end
            SZ_HALF: begin
                for (int i = 16; i < WIDTH; i++) begin
                    ext_o[i] = sext_i & sh[15];
                end
            end
            SZ_WORD: begin
                for (int i = 32; i < WIDTH; i++) begin
                    ext_o[i] = sext_i & sh[31];
                end
            end
            default: ext_o = sh;
        endcase
    end

endmodule

// File: rtl/mdr_handshake.sv
// Memory data register with req/ack handshake: bus load in IDLE, aligned reads with extension,
// lane-replicated writes, and a timeout that always returns the FSM to IDLE via DONE.
module mdr_handshake
    import mdr_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int LANES   = WIDTH / 8,
    localparam int AW      = $clog2(LANES),
    parameter  int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             mdr_in,
    input  logic [WIDTH-1:0] bus_mux_out,
    input  logic             rd_start,
    input  logic             wr_start,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [AW-1:0]    addr_lo,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [LANES-1:0] mem_be,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    mdr_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       size_q, size_d;
    logic             sext_q, sext_d;
    logic [AW-1:0]    off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    logic [WIDTH-1:0]     rd_ext;
    logic [WIDTH-1:0]     wdata_rep;
    logic [MAX_LANES-1:0] be_w;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 timeout_hit;
    logic                 active;

    mdr_lane_align #(.WIDTH(WIDTH)) u_align (
        .rdata_i (mem_rdata),
        .size_i  (size_q),
        .off_i   (off_q),
        .sext_i  (sext_q),
        .ext_o   (rd_ext)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        size_d  = size_q;
        sext_d  = sext_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE: begin
                to_d = 1'b0;
                if (mdr_in) begin
                    q_d = bus_mux_out;
                end
                if (rd_start || wr_start) begin
                    state_d = rd_start ? ST_RD : ST_WR;
                    size_d  = size;
                    sext_d  = sign_ext;
                    off_d   = addr_lo;
                    cnt_d   = '0;
                end
            end
            ST_RD, ST_WR: begin
                // An ack on the final counted cycle still completes the transfer.
                if (mem_ack) begin
                    if (state_q == ST_RD) begin
                        q_d = rd_ext;
                    end
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    cnt_d   = cnt_inc;
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wdata_rep = q_q;
        case (mdr_size_e'(size_q))
            SZ_BYTE: wdata_rep = {LANES{q_q[7:0]}};
            SZ_HALF: wdata_rep = {(LANES/2){q_q[15:0]}};
            SZ_WORD: wdata_rep = {(LANES/4){q_q[31:0]}};
            default: wdata_rep = q_q;
        endcase
    end

    assign be_w = be_gen(mdr_size_e'(size_q), 3'(off_q), 4'(LANES));

    // Request-side outputs decode straight from the state flops so reset drops them at once.
    assign active    = (state_q == ST_RD) || (state_q == ST_WR);
    assign mem_req   = active;
    assign busy      = active;
    assign mem_we    = (state_q == ST_WR);
    assign mem_be    = active ? be_w[LANES-1:0] : '0;
    assign mem_wdata = (state_q == ST_WR) ? wdata_rep : '0;
    assign q         = q_q;
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_DONE) && to_q;

endmodule

// File: tb/tb_mdr_handshake.sv
// Directed bench for mdr_handshake (WIDTH=32, TIMEOUT=4) with hand-computed expectations.
module tb_mdr_handshake;

    logic        clk = 1'b0;
    logic        clr;
    logic        mdr_in;
    logic [31:0] bus_mux_out;
    logic        rd_start;
    logic        wr_start;
    logic [1:0]  size;
    logic        sign_ext;
    logic [1:0]  addr_lo;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] q;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdr_handshake #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .mdr_in      (mdr_in),
        .bus_mux_out (bus_mux_out),
        .rd_start    (rd_start),
        .wr_start    (wr_start),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr_lo     (addr_lo),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0; mdr_in = 1'b0; bus_mux_out = '0; rd_start = 1'b0; wr_start = 1'b0;
        size = 2'b00; sign_ext = 1'b0; addr_lo = 2'd0; mem_rdata = '0; mem_ack = 1'b0;
        #2;
        chk("rst_q",     q,         0);
        chk("rst_req",   mem_req,   0);
        chk("rst_we",    mem_we,    0);
        chk("rst_be",    mem_be,    0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_err",   err,       0);
        tick(); tick();
        clr = 1'b1;
        tick();

        // Bus load in IDLE
        mdr_in = 1'b1; bus_mux_out = 32'hDEADBEEF;
        tick();
        mdr_in = 1'b0;
        chk("load_q",   q,       32'hDEADBEEF);
        chk("load_req", mem_req, 0);

        // Byte read, offset 2, sign extended, ack in first request cycle
        rd_start = 1'b1; size = 2'b00; sign_ext = 1'b1; addr_lo = 2'd2;
        mem_rdata = 32'h1280_3456; mem_ack = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("brd_req",  mem_req, 1);
        chk("brd_we",   mem_we,  0);
        chk("brd_be",   mem_be,  4'b0100);
        chk("brd_busy", busy,    1);
        chk("brd_done0", done,   0);
        tick();
        mem_ack = 1'b0;
        chk("brd_done", done,    1);
        chk("brd_err",  err,     0);
        chk("brd_req0", mem_req, 0);
        chk("brd_busy0", busy,   0);
        chk("brd_q",    q,       32'hFFFF_FF80);
        tick();
        chk("brd_idle", done,    0);

        // Half write at offset 3, value loaded in the same cycle as the start
        mdr_in = 1'b1; bus_mux_out = 32'h0000_ABCD; wr_start = 1'b1; size = 2'b01; addr_lo = 2'd3;
        tick();
        mdr_in = 1'b0; wr_start = 1'b0; bus_mux_out = 32'h5555_5555;
        chk("hwr_we",    mem_we,    1);
        chk("hwr_req",   mem_req,   1);
        chk("hwr_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("hwr_be",    mem_be,    4'b1100);
        tick();
        chk("hwr_we_hold",    mem_we,    1);
        chk("hwr_wdata_hold", mem_wdata, 32'hABCD_ABCD);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("hwr_done", done,   1);
        chk("hwr_err",  err,    0);
        chk("hwr_we0",  mem_we, 0);
        chk("hwr_q",    q,      32'h0000_ABCD);
        tick();

        // Word read that times out (TIMEOUT=4)
        rd_start = 1'b1; size = 2'b10; sign_ext = 1'b0; addr_lo = 2'd0; mem_rdata = 32'h5A5A_1234;
        tick();
        rd_start = 1'b0;
        chk("to_be", mem_be, 4'b1111);
        tick(); tick(); tick();
        chk("to_req_wait",  mem_req, 1);
        chk("to_done_wait", done,    0);
        tick();
        chk("to_done", done,    1);
        chk("to_err",  err,     1);
        chk("to_req0", mem_req, 0);
        chk("to_q",    q,       32'h0000_ABCD);
        tick();
        chk("to_err_clear", err, 0);

        // Same read with ack on the 4th wait cycle
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick(); tick(); tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ack4_done", done, 1);
        chk("ack4_err",  err,  0);
        chk("ack4_q",    q,    32'h5A5A_1234);
        tick();

        // Half read, zero extended, offset 1 aligned down to 0
        rd_start = 1'b1; size = 2'b01; sign_ext = 1'b0; addr_lo = 2'd1;
        mem_rdata = 32'h1280_8456; mem_ack = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("hrd_be", mem_be, 4'b0011);
        tick();
        mem_ack = 1'b0;
        chk("hrd_q", q, 32'h0000_8456);
        tick();

        // Read and write together; busy-time inputs ignored
        rd_start = 1'b1; wr_start = 1'b1; size = 2'b10; addr_lo = 2'd0; mem_rdata = 32'h1122_3344;
        tick();
        chk("both_we",  mem_we,  0);
        chk("both_req", mem_req, 1);
        mdr_in = 1'b1; bus_mux_out = 32'hFFFF_FFFF;
        tick();
        chk("busy_q_kept", q,    32'h0000_8456);
        chk("busy_busy",   busy, 1);
        mdr_in = 1'b0; rd_start = 1'b0; wr_start = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("both_done", done, 1);
        chk("both_q",    q,    32'h1122_3344);
        tick();
        chk("drop_req",  mem_req, 0);
        tick();
        chk("drop_busy", busy,    0);
        chk("drop_q",    q,       32'h1122_3344);

        // Reset in the middle of a read
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("mid_req", mem_req, 1);
        #2 clr = 1'b0;
        #1;
        chk("arst_req",   mem_req,   0);
        chk("arst_busy",  busy,      0);
        chk("arst_q",     q,         0);
        chk("arst_be",    mem_be,    0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_done",  done,      0);
        #2 clr = 1'b1;
        tick();

        // Fresh word read after reset
        rd_start = 1'b1; size = 2'b10; addr_lo = 2'd0; mem_rdata = 32'h0123_4567; mem_ack = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("post_req", mem_req, 1);
        chk("post_be",  mem_be,  4'b1111);
        tick();
        mem_ack = 1'b0;
        chk("post_done", done, 1);
        chk("post_err",  err,  0);
        chk("post_q",    q,    32'h0123_4567);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
